trigger_scan_ctrl: RTL and testbench
====================================

# trigger_scan_ctrl

Sequencer that shares one single-slot trigger comparator across `num_triggers` trigger configurations. It holds the per-trigger tdata2/match-mode/enable/chain configuration and accepts a 64-bit sample value. It then scans the triggers one per cycle through the comparator port and returns a hit mask with chain qualification. It sits between the debug CSR write path and the trigger comparator datapath.

## Interface
- `num_triggers`, 4, number of trigger configurations scanned; ≥2. `IW` = `$clog2(num_triggers)`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `cfg_we`  in  1  config write strobe; accepted when `cfg_ready`.
- `cfg_ready`  out  1  high in IDLE only.
- `cfg_idx`  in  IW  trigger index written.
- `cfg_tdata2`  in  64  compare value for that trigger.
- `cfg_mode`  in  4  match mode; legal: 0,1,2,3,4,5,8,9,12,13.
- `cfg_enable`  in  1  trigger enable.
- `cfg_chain`  in  1  chain this trigger with index+1.
- `cfg_err`  out  1  one-cycle pulse: accepted write carried an illegal mode.
- `smp_valid`  in  1  sample request.
- `smp_ready`  out  1  sample accepted when both high.
- `smp_data`  in  64  sampled CSR value.
- `cmp_tdata2`  out  64  comparator tdata2 operand.
- `cmp_value`  out  64  comparator CSR-value operand.
- `cmp_mode`  out  4  comparator match mode.
- `cmp_match`  in  1  combinational match result for the current operands.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when both high.
- `res_hit_mask`  out  num_triggers  qualified hits, bit i = trigger i.
- `res_any`  out  1  OR of `res_hit_mask`.
- `res_first_idx`  out  IW  lowest set bit of mask; 0 when none.

## Operation
- FSM: IDLE → SCAN → DONE → IDLE.
- IDLE:
  - `cfg_ready`=1, `smp_ready`=!`cfg_we`. A config write has priority over a sample in the same cycle.
  - On accepted `smp_valid`: latch `smp_data`, clear working mask, set scan index k=0, go to SCAN.
- Config write: store tdata2, mode, enable, chain at `cfg_idx`.
  - Illegal mode: entry stored with enable forced 0, and `cfg_err` pulses the next cycle.
  - `cfg_idx` ≥ `num_triggers`: write ignored, no error.
- SCAN, index k:
  - Drive `cmp_tdata2`/`cmp_mode` from entry k and `cmp_value` from the latched sample.
  - Hit_k = enable_k & `cmp_match`.
  - k increments each cycle. After k = `num_triggers`-1, go to DONE.
- Chain group: maximal run k..m where chain is set on k..m-1. Chain on the last trigger is ignored.
  - A running `grp_ok` is ANDed with hit_k.
  - At group end (chain_k=0 or last trigger), if `grp_ok`, set mask bits start..k; then reset `grp_ok`=1 and start=k+1.
  - A disabled member blocks the whole group.
- DONE: `res_valid`=1. Mask, `res_any`, `res_first_idx` stay stable until `res_valid`&`res_ready`, then go to IDLE.
- Outside SCAN, `cmp_*` outputs are 0.

## Timing
- Reset values: state IDLE, all entries zero (disabled, mode 0, chain 0), `cfg_ready`=1, `smp_ready`=1, `res_valid`=0, `res_hit_mask`=0, `res_any`=0, `res_first_idx`=0, `cmp_*`=0, `cfg_err`=0.
- Accept at edge T: SCAN occupies cycles T+1..T+N; `res_valid` rises at T+N+1.
- `res_ready` already high: back in IDLE at T+N+2. Minimum sample period is N+2 cycles.
- `res_ready` low: DONE holds indefinitely with stable outputs. `smp_ready` and `cfg_ready` stay 0 in SCAN and DONE.
- Reset asserted mid-SCAN or in DONE: the next cycle is IDLE with reset values. The in-flight result is discarded and configuration is cleared.
- `cmp_match` is sampled in the same cycle as its operands, with no comparator pipeline stage.

## Configuration
- `TRIG_CHAIN_EN` defined: chain grouping as above.
- `TRIG_CHAIN_EN` undefined: `cfg_chain` is ignored and never stored. Each trigger is its own group, so mask bit k = hit_k.

## Test plan
- Reset, then write trigger 2: tdata2=0x1000, mode 0, enable. Sample 0x1000 → `res_valid` exactly N+1 cycles after accept; mask=0b0100, `res_any`=1, `res_first_idx`=2.
- Triggers 0 and 1 enabled, mode 2, tdata2=0x10, chain on 0 (`TRIG_CHAIN_EN`). Sample 0x20 → mask=0b0011. Disable trigger 1, resample → mask=0b0000. Without the macro, the second sample → 0b0001.
- Write mode 6 to trigger 3 → `cfg_err` pulses one cycle. Sample anything → bit 3 is 0.
- `cfg_we` and `smp_valid` both high in IDLE → write applied, `smp_ready`=0 that cycle. Sample accepted next cycle and sees the new config.
- Hold `res_ready`=0 for 5 cycles in DONE → outputs stable, `smp_ready`=0. Raise it → IDLE the next cycle.
- Assert `rst` low mid-SCAN → next cycle IDLE, `res_valid`=0. A following sample → mask=0, since all entries are disabled.

Source files
------------

// File: rtl/trigger_scan_ctrl.sv
// Time-shares one trigger comparator across num_triggers configurations and returns a hit mask.
// Build option: define TRIG_CHAIN_EN to enable chain grouping of adjacent triggers.
//
// state  | meaning
// S_IDLE | accepts config writes and sample requests
// S_SCAN | one trigger per cycle through the comparator
// S_DONE | result held until consumed
module trigger_scan_ctrl #(
    parameter int num_triggers = 4,
    localparam int IW = $clog2(num_triggers)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_cfg_we,
    output logic                    o_cfg_ready,
    input  logic [IW-1:0]           i_cfg_idx,
    input  logic [63:0]             i_cfg_tdata2,
    input  logic [3:0]              i_cfg_mode,
    input  logic                    i_cfg_enable,
    input  logic                    i_cfg_chain,
    output logic                    o_cfg_err,
    input  logic                    i_smp_valid,
    output logic                    o_smp_ready,
    input  logic [63:0]             i_smp_data,
    output logic [63:0]             o_cmp_tdata2,
    output logic [63:0]             o_cmp_value,
    output logic [3:0]              o_cmp_mode,
    input  logic                    i_cmp_match,
    output logic                    o_res_valid,
    input  logic                    i_res_ready,
    output logic [num_triggers-1:0] o_res_hit_mask,
    output logic                    o_res_any,
    output logic [IW-1:0]           o_res_first_idx
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [63:0]             r_tdata2 [num_triggers];
    logic [3:0]              r_mode   [num_triggers];
    logic [num_triggers-1:0] r_enable;
`ifdef TRIG_CHAIN_EN
    logic [num_triggers-1:0] r_chain;
`endif
    logic [63:0]             r_sample;
    logic [IW-1:0]           r_k;
    logic [IW-1:0]           r_start;
    logic                    r_grp_ok;
    logic [num_triggers-1:0] r_mask;
    logic                    r_cfg_err;

    logic                    w_cfg_acc;
    logic                    w_smp_acc;
    logic                    w_mode_legal;
    logic [num_triggers-1:0] w_idx_sel;
    logic                    w_last;
    logic                    w_hit;
    logic                    w_chain_k;
    logic                    w_grp_ok;
    logic [num_triggers-1:0] w_grp_bits;

    function automatic logic mode_legal(input logic [3:0] m);
        case (m)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd12, 4'd13: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_cfg_ready = 1'b0;
        o_smp_ready = 1'b0;
        o_res_valid = 1'b0;
        w_cfg_acc   = 1'b0;
        w_smp_acc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cfg_ready = 1'b1;
                o_smp_ready = !i_cfg_we;
                w_cfg_acc   = i_cfg_we;
                w_smp_acc   = i_smp_valid && !i_cfg_we;
                if (w_smp_acc) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_res_valid = 1'b1;
                if (i_res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Out-of-range indices select nothing, so such writes vanish without an error.
    always_comb begin
        for (int i = 0; i < num_triggers; i++) begin
            w_idx_sel[i] = (i_cfg_idx == IW'(i));
        end
    end

    assign w_mode_legal = mode_legal(i_cfg_mode);
    assign w_last       = (r_k == IW'(num_triggers - 1));
    assign w_hit        = r_enable[r_k] & i_cmp_match;

`ifdef TRIG_CHAIN_EN
    assign w_chain_k = r_chain[r_k] & !w_last;
`else
    // cfg_chain is not stored in this build; every trigger closes its own group.
    assign w_chain_k = 1'b0 & i_cfg_chain;
`endif

    assign w_grp_ok = r_grp_ok & w_hit;

    always_comb begin
        for (int i = 0; i < num_triggers; i++) begin
            w_grp_bits[i] = (int'(r_start) <= i) && (i <= int'(r_k));
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < num_triggers; i++) begin
                r_tdata2[i] <= '0;
                r_mode[i]   <= '0;
            end
            r_enable  <= '0;
`ifdef TRIG_CHAIN_EN
            r_chain   <= '0;
`endif
            r_sample  <= '0;
            r_k       <= '0;
            r_start   <= '0;
            r_grp_ok  <= 1'b1;
            r_mask    <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg_acc && (|w_idx_sel) && !w_mode_legal;
            if (w_cfg_acc) begin
                for (int i = 0; i < num_triggers; i++) begin
                    if (w_idx_sel[i]) begin
                        r_tdata2[i] <= i_cfg_tdata2;
                        r_mode[i]   <= i_cfg_mode;
                        r_enable[i] <= i_cfg_enable && w_mode_legal;
`ifdef TRIG_CHAIN_EN
                        r_chain[i]  <= i_cfg_chain;
`endif
                    end
                end
            end
            if (w_smp_acc) begin
                r_sample <= i_smp_data;
                r_mask   <= '0;
                r_k      <= '0;
                r_start  <= '0;
                r_grp_ok <= 1'b1;
            end else if (r_state == S_SCAN) begin
                r_k <= r_k + IW'(1);
                if (!w_chain_k) begin
                    if (w_grp_ok) begin
                        r_mask <= r_mask | w_grp_bits;
                    end
                    r_grp_ok <= 1'b1;
                    r_start  <= r_k + IW'(1);
                end else begin
                    r_grp_ok <= w_grp_ok;
                end
            end
        end
    end

    always_comb begin
        o_cmp_tdata2 = '0;
        o_cmp_value  = '0;
        o_cmp_mode   = '0;
        if (r_state == S_SCAN) begin
            o_cmp_tdata2 = r_tdata2[r_k];
            o_cmp_value  = r_sample;
            o_cmp_mode   = r_mode[r_k];
        end
    end

    always_comb begin
        o_res_first_idx = '0;
        for (int i = num_triggers - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                o_res_first_idx = IW'(i);
            end
        end
    end

    assign o_res_hit_mask = r_mask;
    assign o_res_any      = |r_mask;
    assign o_cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_trigger_scan_ctrl.sv
// Bench for trigger_scan_ctrl: vector table plus scoreboard, with hand sequences for
// simultaneous write/sample, result back-pressure and reset during a scan.
module tb_trigger_scan_ctrl;

    localparam int N  = 4;
    localparam int IW = 2;
`ifdef TRIG_CHAIN_EN
    localparam bit CH = 1'b1;
`else
    localparam bit CH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic          cfg_ready;
    logic [IW-1:0] cfg_idx;
    logic [63:0]   cfg_tdata2;
    logic [3:0]    cfg_mode;
    logic          cfg_enable;
    logic          cfg_chain;
    logic          cfg_err;
    logic          smp_valid;
    logic          smp_ready;
    logic [63:0]   smp_data;
    logic [63:0]   cmp_tdata2;
    logic [63:0]   cmp_value;
    logic [3:0]    cmp_mode;
    logic          cmp_match;
    logic          res_valid;
    logic          res_ready;
    logic [N-1:0]  res_hit_mask;
    logic          res_any;
    logic [IW-1:0] res_first_idx;

    int n_tests = 0;
    int n_fail  = 0;
    logic [N-1:0] sb[$];

    always #5 clk = ~clk;

    trigger_scan_ctrl #(.num_triggers(N)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cfg_we(cfg_we), .o_cfg_ready(cfg_ready), .i_cfg_idx(cfg_idx),
        .i_cfg_tdata2(cfg_tdata2), .i_cfg_mode(cfg_mode), .i_cfg_enable(cfg_enable),
        .i_cfg_chain(cfg_chain), .o_cfg_err(cfg_err),
        .i_smp_valid(smp_valid), .o_smp_ready(smp_ready), .i_smp_data(smp_data),
        .o_cmp_tdata2(cmp_tdata2), .o_cmp_value(cmp_value), .o_cmp_mode(cmp_mode),
        .i_cmp_match(cmp_match),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_hit_mask(res_hit_mask),
        .o_res_any(res_any), .o_res_first_idx(res_first_idx)
    );

    // Comparator model: mode 2 is ">=", mode 3 is "<", every other mode is equality.
    always_comb begin
        case (cmp_mode)
            4'd2:    cmp_match = (cmp_value >= cmp_tdata2);
            4'd3:    cmp_match = (cmp_value <  cmp_tdata2);
            default: cmp_match = (cmp_value == cmp_tdata2);
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] low_idx(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            if (m[i]) return IW'(i);
        end
        return '0;
    endfunction

    always @(negedge clk) begin
        #2;
        if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 64'(res_hit_mask), 64'hdead);
            end else begin
                logic [N-1:0] e;
                e = sb.pop_front();
                check("res_hit_mask", 64'(res_hit_mask), 64'(e));
                check("res_any", 64'(res_any), 64'(|e));
                check("res_first_idx", 64'(res_first_idx), 64'(low_idx(e)));
            end
        end
    end

    task automatic cfg_write(input logic [IW-1:0] idx, input logic [63:0] t2, input logic [3:0] md,
                             input logic en, input logic ch, input logic exp_err);
        int n;
        cfg_we = 1'b1; cfg_idx = idx; cfg_tdata2 = t2; cfg_mode = md;
        cfg_enable = en; cfg_chain = ch;
        #1;
        n = 0;
        while (!cfg_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n == 20) check("cfg_ready_timeout", 64'(cfg_ready), 64'd1);
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        check("cfg_err", 64'(cfg_err), 64'(exp_err));
        @(negedge clk); #1;
        check("cfg_err_pulse_end", 64'(cfg_err), 64'd0);
    endtask

    task automatic accept_sample(input logic [63:0] d);
        int n;
        smp_valid = 1'b1; smp_data = d;
        #1;
        n = 0;
        while (!smp_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n == 20) check("smp_ready_timeout", 64'(smp_ready), 64'd1);
        @(negedge clk);
        smp_valid = 1'b0;
        #1;
    endtask

    // Called one half-cycle after the accept edge; valid must appear N edges later.
    task automatic wait_valid(input bit do_chk, input int k_chk, input logic [63:0] t2,
                              input logic [3:0] md, input logic [63:0] d);
        int cnt;
        cnt = 0;
        while (cnt < 40 && !res_valid) begin
            if (do_chk && cnt == k_chk) begin
                check("cmp_tdata2", cmp_tdata2, t2);
                check("cmp_mode", 64'(cmp_mode), 64'(md));
                check("cmp_value", cmp_value, d);
            end
            if (cnt == 1) check("smp_ready_in_scan", 64'(smp_ready), 64'd0);
            @(negedge clk); #1; cnt++;
        end
        check("latency", 64'(cnt), 64'(N));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    typedef struct {
        logic [IW-1:0] idx;
        logic [63:0]   tdata2;
        logic [3:0]    mode;
        logic          en;
        logic          chain;
        logic          exp_err;
        logic [63:0]   sample;
        logic [N-1:0]  exp_mask;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{2'd2, 64'h1000, 4'd0,  1'b1, 1'b0, 1'b0, 64'h1000, 4'b0100};
        vecs[1]  = '{2'd0, 64'h10,   4'd2,  1'b1, 1'b1, 1'b0, 64'h20,   CH ? 4'b0000 : 4'b0001};
        vecs[2]  = '{2'd1, 64'h10,   4'd2,  1'b1, 1'b0, 1'b0, 64'h20,   4'b0011};
        vecs[3]  = '{2'd1, 64'h10,   4'd2,  1'b0, 1'b0, 1'b0, 64'h20,   CH ? 4'b0000 : 4'b0001};
        vecs[4]  = '{2'd3, 64'h0,    4'd6,  1'b1, 1'b0, 1'b1, 64'h0,    4'b0000};
        vecs[5]  = '{2'd1, 64'h10,   4'd2,  1'b1, 1'b0, 1'b0, 64'h50,   4'b0011};
        vecs[6]  = '{2'd2, 64'h100,  4'd3,  1'b1, 1'b1, 1'b0, 64'h50,   CH ? 4'b0011 : 4'b0111};
        vecs[7]  = '{2'd3, 64'h50,   4'd13, 1'b1, 1'b1, 1'b0, 64'h50,   4'b1111};
        vecs[8]  = '{2'd0, 64'hffff, 4'd12, 1'b1, 1'b1, 1'b0, 64'h50,   CH ? 4'b1100 : 4'b1110};
        vecs[9]  = '{2'd0, 64'h1,    4'd8,  1'b1, 1'b0, 1'b0, 64'h40,   CH ? 4'b0010 : 4'b0110};
        vecs[10] = '{2'd0, 64'h40,   4'd15, 1'b1, 1'b0, 1'b1, 64'h40,   CH ? 4'b0010 : 4'b0110};

        rst = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_tdata2 = '0; cfg_mode = '0;
        cfg_enable = 1'b0; cfg_chain = 1'b0; smp_valid = 1'b0; smp_data = '0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_smp_ready", 64'(smp_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_mask", 64'(res_hit_mask), 64'd0);
        check("rst_any", 64'(res_any), 64'd0);
        check("rst_first", 64'(res_first_idx), 64'd0);
        check("rst_cmp_tdata2", cmp_tdata2, 64'd0);
        check("rst_cmp_value", cmp_value, 64'd0);
        check("rst_cmp_mode", 64'(cmp_mode), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        rst = 1'b1;
        @(negedge clk); #1;

        for (int v = 0; v < 11; v++) begin
            cfg_write(vecs[v].idx, vecs[v].tdata2, vecs[v].mode, vecs[v].en, vecs[v].chain,
                      vecs[v].exp_err);
            sb.push_back(vecs[v].exp_mask);
            accept_sample(vecs[v].sample);
            wait_valid(1'b1, int'(vecs[v].idx), vecs[v].tdata2, vecs[v].mode, vecs[v].sample);
            drain();
        end

        // Write and sample offered together: write wins, sample follows with new config.
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_tdata2 = 64'h77; cfg_mode = 4'd0;
        cfg_enable = 1'b1; cfg_chain = 1'b0;
        smp_valid = 1'b1; smp_data = 64'h77;
        #1;
        check("both_smp_ready", 64'(smp_ready), 64'd0);
        check("both_cfg_ready", 64'(cfg_ready), 64'd1);
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        check("both_smp_ready_next", 64'(smp_ready), 64'd1);
        sb.push_back(CH ? 4'b0011 : 4'b0111);
        @(negedge clk);
        smp_valid = 1'b0;
        #1;
        wait_valid(1'b1, 0, 64'h77, 4'd0, 64'h77);
        drain();

        // Back-pressure: result must hold while res_ready is low.
        res_ready = 1'b0;
        sb.push_back(4'b1110);
        accept_sample(64'h50);
        wait_valid(1'b0, 0, '0, '0, '0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_mask", 64'(res_hit_mask), 64'(4'b1110));
            check("hold_first", 64'(res_first_idx), 64'd1);
            check("hold_smp_ready", 64'(smp_ready), 64'd0);
            check("hold_cfg_ready", 64'(cfg_ready), 64'd0);
        end
        res_ready = 1'b1;
        @(negedge clk); #1;
        check("release_idle", 64'(cfg_ready), 64'd1);
        check("release_valid", 64'(res_valid), 64'd0);
        check("release_popped", 64'(sb.size()), 64'd0);

        // Reset two cycles into a scan discards the result and the configuration.
        accept_sample(64'h50);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("midrst_res_valid", 64'(res_valid), 64'd0);
        check("midrst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("midrst_smp_ready", 64'(smp_ready), 64'd1);
        check("midrst_mask", 64'(res_hit_mask), 64'd0);
        check("midrst_cmp_tdata2", cmp_tdata2, 64'd0);
        rst = 1'b1;
        @(negedge clk); #1;
        sb.push_back(4'b0000);
        accept_sample(64'h50);
        wait_valid(1'b0, 0, '0, '0, '0);
        drain();

        repeat (3) @(negedge clk);
        #1;
        check("final_queue_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
